// File: rtl/collatz_sweep_ctrl_pkg.sv
// Shared types for the Collatz sweep controller: sequencer states and default core width.
package collatz_sweep_ctrl_pkg;

  // Width of the core's argument/result datapath.
  localparam int unsigned IntN = 27;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/collatz_sweep_ctrl_sweep_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module sweep_watchdog #(
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntLast);

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// Sweep sequencer: feeds arguments cfg_first..cfg_last to the Collatz core one at a time,
// collects results, and tracks the best result, its argument and the result count.
module collatz_sweep_ctrl
  import collatz_sweep_ctrl_pkg::*;
#(
  parameter int unsigned W       = IntN,
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [W-1:0]     cfg_first_i,
  input  logic [W-1:0]     cfg_last_i,
  output logic             core_in_valid_o,
  input  logic             core_in_ready_i,
  output logic [W-1:0]     core_arg_o,
  input  logic             core_out_valid_i,
  output logic             core_out_ready_o,
  input  logic [W-1:0]     core_result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_err_o,
  output logic [W-1:0]     best_arg_o,
  output logic [W-1:0]     best_result_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CountMax = '1;

  state_e           state_q, state_d;
  logic [W-1:0]     arg_q, arg_d, last_q, last_d;
  logic [W-1:0]     best_arg_q, best_arg_d, best_result_q, best_result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_pend_q, stop_pend_d, done_q, done_d, timeout_err_q, timeout_err_d;
  logic             busy_q, busy_d, in_valid_q, in_valid_d, out_ready_q, out_ready_d;
  logic             wd_expired;

  logic start_ok, range_ok, stopping, at_last;
  assign start_ok = start_i && (state_q != StIssue) && (state_q != StWait);
  assign range_ok = (cfg_first_i <= cfg_last_i);
  // A stop arriving on the same cycle as the result still ends the sweep.
  assign stopping = stop_pend_q || stop_i;
  assign at_last  = (arg_q == last_q);

  sweep_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != StWait),
    .enable_i (state_q == StWait),
    .expired_o(wd_expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIssue: begin
        if (core_in_ready_i) begin
          state_d = StWait;
        end else if (stop_i) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // A result on the expiry cycle takes precedence over the watchdog.
        if (core_out_valid_i) begin
          if (stopping)     state_d = StIdle;
          else if (at_last) state_d = StDone;
          else              state_d = StIssue;
        end else if (wd_expired) begin
          state_d = StErr;
        end
      end
      // Idle, Done and Err all accept a new start.
      default: state_d = (start_i && range_ok) ? StIssue : StIdle;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    arg_d         = arg_q;
    last_d        = last_q;
    best_arg_d    = best_arg_q;
    best_result_d = best_result_q;
    count_d       = count_q;
    stop_pend_d   = stop_pend_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    in_valid_d    = (state_d == StIssue);
    out_ready_d   = (state_d == StWait);
    busy_d        = (state_d == StIssue) || (state_d == StWait);
    if (start_ok) begin
      arg_d         = cfg_first_i;
      last_d        = cfg_last_i;
      best_arg_d    = '0;
      best_result_d = '0;
      count_d       = '0;
      stop_pend_d   = 1'b0;
      timeout_err_d = 1'b0;
      done_d        = !range_ok;
    end
    if (state_q == StIssue && core_in_ready_i) begin
      stop_pend_d = stop_i;
    end
    if (state_q == StWait) begin
      if (stop_i) stop_pend_d = 1'b1;
      if (core_out_valid_i) begin
        if (count_q != CountMax) count_d = count_q + 1'b1;
        if ((core_result_i > best_result_q) || (count_q == '0)) begin
          best_result_d = core_result_i;
          best_arg_d    = arg_q;
        end
        // Equality is tested before incrementing, so an all-ones last never wraps.
        if (!stopping && !at_last) arg_d = arg_q + 1'b1;
        if (!stopping && at_last)  done_d = 1'b1;
      end else if (wd_expired) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arg_q         <= '0;
      last_q        <= '0;
      best_arg_q    <= '0;
      best_result_q <= '0;
      count_q       <= '0;
      stop_pend_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
    end else begin
      arg_q         <= arg_d;
      last_q        <= last_d;
      best_arg_q    <= best_arg_d;
      best_result_q <= best_result_d;
      count_q       <= count_d;
      stop_pend_q   <= stop_pend_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      in_valid_q    <= in_valid_d;
      out_ready_q   <= out_ready_d;
    end
  end

  assign core_in_valid_o  = in_valid_q;
  assign core_out_ready_o = out_ready_q;
  assign core_arg_o       = arg_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign timeout_err_o    = timeout_err_q;
  assign best_arg_o       = best_arg_q;
  assign best_result_o    = best_result_q;
  assign count_o          = count_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: a core stub answering with the Collatz total stopping time
// (or fixed values) after a programmable latency, and a sequential reference model of a sweep.
module tb_collatz_sweep_ctrl;

  localparam int unsigned W       = 27;
  localparam int unsigned CNT_W   = 27;
  localparam int unsigned TIMEOUT = 16;

  localparam int ModeCollatz = 0;
  localparam int ModeConst5  = 1;
  localparam int ModeZero    = 2;
  localparam int ModeNever   = 3;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, stop_i;
  logic [W-1:0]     cfg_first_i, cfg_last_i;
  logic             core_in_valid_o, core_in_ready_i;
  logic [W-1:0]     core_arg_o;
  logic             core_out_valid_i, core_out_ready_o;
  logic [W-1:0]     core_result_i;
  logic             busy_o, done_o, timeout_err_o;
  logic [W-1:0]     best_arg_o, best_result_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;

  collatz_sweep_ctrl #(
    .W      (W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .cfg_first_i     (cfg_first_i),
    .cfg_last_i      (cfg_last_i),
    .core_in_valid_o (core_in_valid_o),
    .core_in_ready_i (core_in_ready_i),
    .core_arg_o      (core_arg_o),
    .core_out_valid_i(core_out_valid_i),
    .core_out_ready_o(core_out_ready_o),
    .core_result_i   (core_result_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .timeout_err_o   (timeout_err_o),
    .best_arg_o      (best_arg_o),
    .best_result_o   (best_result_o),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_time_limit got running exp finished");
    $fatal(1);
  end

  function automatic int tst(input longint unsigned n0);
    longint unsigned n = n0;
    int s = 0;
    if (n == 0) return 0;
    while (n != 1) begin
      if (n[0]) n = 3 * n + 1;
      else      n = n / 2;
      s++;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] stub_result(input int mode, input logic [W-1:0] a);
    case (mode)
      ModeCollatz: return W'(tst(longint'(a)));
      ModeConst5:  return W'(5);
      default:     return '0;
    endcase
  endfunction

  // Walks the range in order, as the sweep is defined, and stops after stop_arg if asked.
  task automatic model_sweep(input longint unsigned first, last, input int mode,
                             input bit do_stop, input longint unsigned stop_arg,
                             output logic [CNT_W-1:0] cnt, output logic [W-1:0] barg,
                             output logic [W-1:0] bres, output bit exp_done);
    logic [W-1:0] r;
    cnt = '0; barg = '0; bres = '0; exp_done = 1'b1;
    if (first > last) return;
    for (longint unsigned a = first; a <= last; a++) begin
      r = stub_result(mode, W'(a));
      if (cnt == 0 || r > bres) begin
        bres = r;
        barg = W'(a);
      end
      cnt++;
      if (do_stop && a == stop_arg) begin
        exp_done = 1'b0;
        break;
      end
    end
  endtask

  // Starts a sweep and plays the core until busy drops (or a cycle budget runs out).
  task automatic run_sweep(input logic [W-1:0] first, last, input int lat, bp, mode,
                           input bit do_stop, input logic [W-1:0] stop_arg,
                           output int transfers, output int cycles, output bit unstable,
                           output bit hung);
    bit pending = 0, stopped = 0, prev_valid = 0;
    int lat_cnt = 0, bp_cnt = 0;
    logic [W-1:0] held = '0, prev_arg = '0;
    transfers = 0; cycles = 0; unstable = 0;
    cfg_first_i = first; cfg_last_i = last; start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    while (busy_o && cycles < 2000) begin
      if (core_in_valid_o && prev_valid && core_arg_o !== prev_arg) unstable = 1;
      prev_valid = core_in_valid_o;
      prev_arg   = core_arg_o;
      stop_i = 0;
      core_in_ready_i = 0;
      if (core_in_valid_o) begin
        if (bp_cnt < bp) begin
          bp_cnt++;
        end else begin
          core_in_ready_i = 1;
          bp_cnt = 0; pending = 1; held = core_arg_o; lat_cnt = lat;
          transfers++;
        end
      end
      core_out_valid_i = 0;
      if (pending && core_out_ready_o) begin
        if (do_stop && !stopped && held == stop_arg) begin
          stop_i = 1;
          stopped = 1;
        end
        if (lat_cnt == 0 && mode != ModeNever) begin
          core_out_valid_i = 1;
          core_result_i = stub_result(mode, held);
          pending = 0;
        end else if (lat_cnt > 0) begin
          lat_cnt--;
        end
      end
      @(negedge clk_i);
      cycles++;
    end
    hung = busy_o;
    core_in_ready_i = 0; core_out_valid_i = 0; stop_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({core_in_valid_o, core_out_ready_o, core_arg_o, busy_o, done_o, timeout_err_o,
         best_arg_o, best_result_o, count_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b count=%0d exp all zero",
               busy_o, done_o, count_o);
    end
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    int tr, cy; bit un, hg;
    logic [CNT_W-1:0] ec; logic [W-1:0] ea, er; bit ed;
    model_sweep(1, 10, ModeCollatz, 0, 0, ec, ea, er, ed);
    run_sweep(1, 10, 3, 0, ModeCollatz, 0, '0, tr, cy, un, hg);
    checks++; if (hg) begin errors++; $display("FAIL basic_hang got busy exp idle"); end
    checks++; if (count_o !== ec) begin
      errors++; $display("FAIL basic_count got %0d exp %0d", count_o, ec); end
    checks++; if (best_result_o !== er || er !== 27'd19) begin
      errors++; $display("FAIL basic_best_result got %0d exp 19", best_result_o); end
    checks++; if (best_arg_o !== ea || ea !== 27'd9) begin
      errors++; $display("FAIL basic_best_arg got %0d exp 9", best_arg_o); end
    checks++; if (done_o !== 1'b1 || timeout_err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_flags got done=%b err=%b busy=%b exp 1 0 0",
                         done_o, timeout_err_o, busy_o); end
  endtask

  task automatic test_throughput();
    int tr, cy; bit un, hg;
    run_sweep(1, 8, 0, 0, ModeCollatz, 0, '0, tr, cy, un, hg);
    checks++; if (cy != 16 || hg) begin
      errors++; $display("FAIL throughput_cycles got %0d exp 16", cy); end
  endtask

  task automatic test_backpressure();
    int tr, cy; bit un, hg;
    run_sweep(3, 3, 2, 5, ModeCollatz, 0, '0, tr, cy, un, hg);
    checks++; if (un || hg) begin
      errors++; $display("FAIL bp_arg_stable got unstable=%b hung=%b exp 0 0", un, hg); end
    checks++; if (tr != 1 || count_o !== 27'd1) begin
      errors++; $display("FAIL bp_transfers got %0d count=%0d exp 1 1", tr, count_o); end
    checks++; if (best_result_o !== 27'd7 || best_arg_o !== 27'd3) begin
      errors++; $display("FAIL bp_best got %0d@%0d exp 7@3", best_result_o, best_arg_o); end
  endtask

  task automatic test_empty();
    cfg_first_i = 5; cfg_last_i = 4; start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    checks++;
    if (done_o !== 1'b1 || count_o !== '0 || busy_o !== 1'b0 || core_in_valid_o !== 1'b0) begin
      errors++; $display("FAIL empty_range got done=%b count=%0d busy=%b valid=%b exp 1 0 0 0",
                         done_o, count_o, busy_o, core_in_valid_o);
    end
  endtask

  task automatic test_edge();
    int tr, cy; bit un, hg;
    logic [W-1:0] top_arg = '1;
    run_sweep(top_arg, top_arg, 1, 0, ModeZero, 0, '0, tr, cy, un, hg);
    checks++; if (hg || tr != 1 || count_o !== 27'd1) begin
      errors++; $display("FAIL edge_count got tr=%0d count=%0d hung=%b exp 1 1 0",
                         tr, count_o, hg); end
    checks++; if (best_arg_o !== top_arg || best_result_o !== '0 || done_o !== 1'b1) begin
      errors++; $display("FAIL edge_best got arg=%h res=%0d done=%b exp %h 0 1",
                         best_arg_o, best_result_o, done_o, top_arg); end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || core_in_valid_o !== 1'b0) begin
      errors++; $display("FAIL edge_idle got busy=%b valid=%b exp 0 0",
                         busy_o, core_in_valid_o); end
  endtask

  task automatic test_stop();
    int tr, cy; bit un, hg;
    logic [CNT_W-1:0] ec; logic [W-1:0] ea, er; bit ed;
    model_sweep(1, 10, ModeCollatz, 1, 4, ec, ea, er, ed);
    run_sweep(1, 10, 3, 0, ModeCollatz, 1, 27'd4, tr, cy, un, hg);
    checks++; if (hg || count_o !== ec || ec !== 27'd4) begin
      errors++; $display("FAIL stop_count got %0d exp 4", count_o); end
    checks++; if (best_result_o !== er || best_arg_o !== ea || er !== 27'd7) begin
      errors++; $display("FAIL stop_best got %0d@%0d exp 7@3", best_result_o, best_arg_o); end
    repeat (2) @(negedge clk_i);
    checks++; if (done_o !== ed || busy_o !== 1'b0 || core_in_valid_o !== 1'b0) begin
      errors++; $display("FAIL stop_idle got done=%b busy=%b valid=%b exp 0 0 0",
                         done_o, busy_o, core_in_valid_o); end
  endtask

  task automatic test_stop_issue();
    cfg_first_i = 1; cfg_last_i = 5; start_i = 1; core_in_ready_i = 0;
    @(negedge clk_i);
    start_i = 0;
    @(negedge clk_i);
    stop_i = 1;
    @(negedge clk_i);
    stop_i = 0;
    checks++;
    if (busy_o !== 1'b0 || core_in_valid_o !== 1'b0 || done_o !== 1'b0 || count_o !== '0) begin
      errors++; $display("FAIL stop_issue got busy=%b valid=%b done=%b count=%0d exp 0 0 0 0",
                         busy_o, core_in_valid_o, done_o, count_o);
    end
  endtask

  task automatic test_timeout();
    int k = 0, w = 0;
    cfg_first_i = 1; cfg_last_i = 1; start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    while (!core_out_ready_o && w < 50) begin
      core_in_ready_i = core_in_valid_o;
      @(negedge clk_i);
      w++;
    end
    core_in_ready_i = 0;
    while (!timeout_err_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    checks++; if (k != 16) begin
      errors++; $display("FAIL timeout_latency got %0d exp 16", k); end
    checks++; if (busy_o !== 1'b0 || core_out_ready_o !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got busy=%b ready=%b exp 0 0",
                         busy_o, core_out_ready_o); end
    cfg_first_i = 5; cfg_last_i = 4; start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    checks++; if (timeout_err_o !== 1'b0 || done_o !== 1'b1) begin
      errors++; $display("FAIL timeout_clear got err=%b done=%b exp 0 1", timeout_err_o, done_o); end
  endtask

  task automatic test_ties();
    int tr, cy; bit un, hg;
    run_sweep(1, 4, 1, 0, ModeConst5, 0, '0, tr, cy, un, hg);
    checks++; if (hg || best_arg_o !== 27'd1 || best_result_o !== 27'd5 || count_o !== 27'd4) begin
      errors++; $display("FAIL ties got arg=%0d res=%0d count=%0d exp 1 5 4",
                         best_arg_o, best_result_o, count_o); end
  endtask

  task automatic test_reset_mid();
    cfg_first_i = 1; cfg_last_i = 10; start_i = 1; core_in_ready_i = 1; core_out_valid_i = 0;
    @(negedge clk_i);
    start_i = 0;
    repeat (2) @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_busy got %b exp 1", busy_o); end
    rst_i = 1;
    @(negedge clk_i);
    checks++;
    if ({core_in_valid_o, core_out_ready_o, core_arg_o, busy_o, done_o, timeout_err_o,
         best_arg_o, best_result_o, count_o} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got busy=%b arg=%0d exp all zero",
                         busy_o, core_arg_o);
    end
    rst_i = 0; core_in_ready_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    int tr, cy, lat, bp; bit un, hg;
    logic [W-1:0] first, last;
    logic [CNT_W-1:0] ec; logic [W-1:0] ea, er; bit ed;
    for (int i = 0; i < 20; i++) begin
      first = W'($urandom_range(1, 60));
      last  = first + W'($urandom_range(0, 8)) - 1'b1;
      lat   = $urandom_range(0, 4);
      bp    = $urandom_range(0, 2);
      model_sweep(longint'(first), longint'(last), ModeCollatz, 0, 0, ec, ea, er, ed);
      run_sweep(first, last, lat, bp, ModeCollatz, 0, '0, tr, cy, un, hg);
      checks++;
      if (hg || un || count_o !== ec || best_arg_o !== ea || best_result_o !== er ||
          done_o !== ed || CNT_W'(tr) !== ec) begin
        errors++;
        $display("FAIL random_%0d [%0d..%0d] got cnt=%0d best=%0d@%0d done=%b exp %0d %0d@%0d %b",
                 i, first, last, count_o, best_result_o, best_arg_o, done_o, ec, er, ea, ed);
      end
    end
  endtask

  initial begin
    rst_i = 1; start_i = 0; stop_i = 0; cfg_first_i = '0; cfg_last_i = '0;
    core_in_ready_i = 0; core_out_valid_i = 0; core_result_i = '0;
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_empty();
    test_edge();
    test_stop();
    test_stop_issue();
    test_timeout();
    test_ties();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
